// File: rtl/program_loader_pkg.sv
// Shared loader types and default instruction-memory geometry.
// Optional feature macro used by the loader: LOADER_CHECKSUM_EN.
package program_loader_pkg;

  localparam int DEF_MEM_SIZE  = 128;
  localparam int DEF_WORD_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Packs an 8-bit stream little-endian into one instruction word.
// Unfilled upper bytes stay zero because the word clears on clr.
module program_loader_byte_assembler
  import program_loader_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [7:0]           byte_in,
  output logic [WORD_SIZE-1:0] word,
  output logic                 last_byte
);

  localparam int NB = WORD_SIZE / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [IW-1:0] idx;

  assign last_byte = (idx == IW'(NB - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word <= '0;
      idx  <= '0;
    end else if (en) begin
      for (int k = 0; k < NB; k++) begin
        if (idx == IW'(k)) word[8*k +: 8] <= byte_in;
      end
      idx <= last_byte ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a byte image into instruction memory, holding the core in reset.
// Define LOADER_CHECKSUM_EN to accumulate a word checksum on chk.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MEM_SIZE  = DEF_MEM_SIZE,
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       s_valid,
  input  logic [7:0]                 s_data,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic                       mem_wr,
  output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]       mem_data,
  output logic                       core_rst,
  output logic                       done,
  output logic                       ovf,
  output logic [$clog2(MEM_SIZE):0]  word_count,
  output logic [WORD_SIZE-1:0]       chk
);

  localparam int AW = $clog2(MEM_SIZE);
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_SIZE - 1);

  loader_state_t state;
  logic          last_seen;
  logic          go;
  logic          take;
  logic          asm_last;
  logic          at_end;

  assign go     = start && (state == IDLE || state == DONE);
  assign take   = s_valid && (state == LOAD);
  assign at_end = (mem_addr == LAST_ADDR);

  assign s_ready  = (state == LOAD);
  assign mem_wr   = (state == WRITE);
  assign done     = (state == DONE);
  assign core_rst = (state != DONE);

  // Clearing on every WRITE readies the next word and drops stale bytes.
  program_loader_byte_assembler #(
    .WORD_SIZE (WORD_SIZE)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (go || (state == WRITE)),
    .en        (take),
    .byte_in   (s_data),
    .word      (mem_data),
    .last_byte (asm_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_addr   <= '0;
      word_count <= '0;
      ovf        <= 1'b0;
      last_seen  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            mem_addr   <= '0;
            word_count <= '0;
            ovf        <= 1'b0;
            last_seen  <= 1'b0;
          end
        end
        LOAD: begin
          if (take && (asm_last || s_last)) begin
            state     <= WRITE;
            last_seen <= s_last;
          end
        end
        WRITE: begin
          word_count <= word_count + (AW+1)'(1);
          if (last_seen || at_end) begin
            state <= DONE;
            ovf   <= !last_seen;
          end else begin
            state    <= LOAD;
            mem_addr <= mem_addr + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [WORD_SIZE-1:0] sum;

  always_ff @(posedge clk) begin
    if (rst || go) begin
      sum <= '0;
    end else if (state == WRITE) begin
      sum <= sum + mem_data;
    end
  end

  assign chk = sum;
`else
  assign chk = '0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Table-driven bench for program_loader with a write scoreboard.
module tb_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start4;
  logic       s_valid, s_last;
  logic [7:0] s_data;

  logic        s_ready, mem_wr, core_rst, done, ovf;
  logic [6:0]  mem_addr;
  logic [31:0] mem_data, chk;
  logic [7:0]  word_count;

  logic        s_ready4, mem_wr4, core_rst4, done4, ovf4;
  logic [1:0]  mem_addr4;
  logic [31:0] mem_data4, chk4;
  logic [2:0]  wc4;

  program_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data(mem_data), .core_rst(core_rst), .done(done),
    .ovf(ovf), .word_count(word_count), .chk(chk)
  );

  program_loader #(.MEM_SIZE(4), .WORD_SIZE(32)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready4), .mem_wr(mem_wr4), .mem_addr(mem_addr4),
    .mem_data(mem_data4), .core_rst(core_rst4), .done(done4),
    .ovf(ovf4), .word_count(wc4), .chk(chk4)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef logic [7:0] byteq_t[$];

  typedef struct {
    bit          sel4;
    bit          gap;
    int          n;
    logic [7:0]  first;
    logic [7:0]  step;
    int          wc;
    bit          ovf;
    logic [31:0] w[4];
  } vec_t;

  wr_t  sb[$];
  wr_t  sb4[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tv[6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (mem_wr) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected none",
                 mem_addr, mem_data);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(mem_addr), e.addr);
        check("wr_data", mem_data, e.data);
      end
    end
    if (mem_wr4) begin
      if (sb4.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write4: got addr %0d data %h, expected none",
                 mem_addr4, mem_data4);
      end else begin
        e = sb4.pop_front();
        check("wr4_addr", 32'(mem_addr4), e.addr);
        check("wr4_data", mem_data4, e.data);
      end
    end
  end

  function automatic vec_t mk(bit sel4, bit gap, int n, logic [7:0] first,
                              logic [7:0] step, int wc, bit ov,
                              logic [31:0] w0, logic [31:0] w1,
                              logic [31:0] w2, logic [31:0] w3);
    vec_t v;
    v.sel4 = sel4; v.gap = gap; v.n = n;
    v.first = first; v.step = step; v.wc = wc; v.ovf = ov;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    return v;
  endfunction

  task automatic run_image(input byteq_t b, input bit sel4, input bit gap);
    int t;
    bit rdy, dn;
    if (sel4) start4 = 1'b1;
    else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start4 = 1'b0;
    for (int i = 0; i < b.size(); i++) begin
      s_valid = 1'b1;
      s_data  = b[i];
      s_last  = (i == b.size() - 1);
      t = 0;
      rdy = sel4 ? s_ready4 : s_ready;
      dn  = sel4 ? done4 : done;
      while (!rdy && !dn && t < 20) begin
        @(negedge clk);
        t++;
        rdy = sel4 ? s_ready4 : s_ready;
        dn  = sel4 ? done4 : done;
      end
      if (dn) break;
      if (!rdy) begin
        check("accept_timeout", 32'(rdy), 32'd1);
        break;
      end
      @(negedge clk);
      if (gap) begin
        s_valid = 1'b0;
        if (!sel4 && (i == 1 || i == 3)) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    t = 0;
    while (!(sel4 ? done4 : done) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("done_reached", 32'(sel4 ? done4 : done), 32'd1);
  endtask

  task automatic after_load(input string tag, input bit sel4, input int wc,
                            input bit ov, input logic [31:0] exp_chk);
    check({tag, "_core_rst"}, 32'(sel4 ? core_rst4 : core_rst), 32'd0);
    check({tag, "_wc"}, sel4 ? 32'(wc4) : 32'(word_count), 32'(wc));
    check({tag, "_ovf"}, 32'(sel4 ? ovf4 : ovf), 32'(ov));
    check({tag, "_chk"}, sel4 ? chk4 : chk, exp_chk);
    s_valid = 1'b1;
    s_data  = 8'h5A;
    for (int c = 0; c < 3; c++) begin
      check({tag, "_ready_low"}, 32'(sel4 ? s_ready4 : s_ready), 32'd0);
      @(negedge clk);
    end
    s_valid = 1'b0;
    check({tag, "_sb_empty"}, 32'(sel4 ? sb4.size() : sb.size()), 32'd0);
  endtask

  task automatic run_vec(input int k);
    byteq_t      b;
    logic [7:0]  v;
    logic [31:0] sum;
    wr_t         e;
    v = tv[k].first;
    for (int i = 0; i < tv[k].n; i++) begin
      b.push_back(v);
      v = v + tv[k].step;
    end
    sum = '0;
    for (int i = 0; i < tv[k].wc; i++) begin
      e.addr = 32'(i);
      e.data = tv[k].w[i];
      if (tv[k].sel4) sb4.push_back(e);
      else sb.push_back(e);
      sum = sum + tv[k].w[i];
    end
`ifndef LOADER_CHECKSUM_EN
    sum = '0;
`endif
    run_image(b, tv[k].sel4, tv[k].gap);
    after_load($sformatf("vec%0d", k), tv[k].sel4, tv[k].wc, tv[k].ovf, sum);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byteq_t b;
    wr_t    e;

    tv[0] = mk(0, 0, 8, 8'h01, 8'h01, 2, 0,
               32'h04030201, 32'h08070605, 0, 0);
    tv[1] = mk(0, 0, 5, 8'hAA, 8'h11, 2, 0,
               32'hDDCCBBAA, 32'h000000EE, 0, 0);
    tv[2] = mk(1, 0, 20, 8'h10, 8'h01, 4, 1,
               32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C);
    tv[3] = mk(0, 1, 8, 8'h01, 8'h01, 2, 0,
               32'h04030201, 32'h08070605, 0, 0);
    tv[4] = mk(0, 0, 3, 8'h55, 8'h01, 1, 0,
               32'h00575655, 0, 0, 0);
    tv[5] = mk(0, 0, 4, 8'hF0, 8'h01, 1, 0,
               32'hF3F2F1F0, 0, 0, 0);

    rst = 1'b1; start = 1'b0; start4 = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_wc", 32'(word_count), 32'd0);
    check("rst_chk", chk, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ignores_valid", 32'(s_ready), 32'd0);

    for (int k = 0; k < 6; k++) run_vec(k);

    // Abort a load two bytes into a word; nothing may be written.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b1; s_data = 8'h11;
    @(negedge clk);
    s_data = 8'h22;
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 32'(s_ready), 32'd0);
    check("abort_core_rst", 32'(core_rst), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_wc", 32'(word_count), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_write", 32'(sb.size()), 32'd0);
    run_vec(4);

    // Checksum wrap: FFFFFFFF + 00000002.
    b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    e.addr = 32'd0; e.data = 32'hFFFFFFFF; sb.push_back(e);
    e.addr = 32'd1; e.data = 32'h00000002; sb.push_back(e);
    run_image(b, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    after_load("cksum", 1'b0, 2, 1'b0, 32'h00000001);
`else
    after_load("cksum", 1'b0, 2, 1'b0, 32'h00000000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
